fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage that drives the IF side of the IF/ID pipeline register: instr_f, Address_f, PC4_f, plus fetch_valid.
- Owns the PC and issues one-outstanding-request fetches to instruction memory over a valid/ready request channel and a valid-only response channel.
- Honours stall_f from the hazard unit and redirect requests from branch/jump resolution, discarding wrong-path responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, value driven on instr_f when there is no valid instruction.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  32  fetch address; word aligned.
- imem_rsp_valid  in  1  response data valid; one pulse per accepted request, in order, no backpressure.
- imem_rsp_data  in  32  fetched instruction.
- stall_f  in  1  decode cannot accept; hold the output slot.
- redirect_valid  in  1  redirect fetch to redirect_pc.
- redirect_pc  in  32  new PC; bits [1:0] forced to 0.
- instr_f  out  32  instruction to IF/ID.
- Address_f  out  32  PC of instr_f.
- PC4_f  out  32  Address_f + 4.
- fetch_valid  out  1  output slot holds a valid instruction.

Behaviour:
- Reset (reset==0, asynchronous):
  - pc=RESET_PC; state=REQ; pending buffer empty.
  - fetch_valid=0, instr_f=NOP_INSTR, Address_f=0, PC4_f=0.
  - imem_req_valid forced to 0 while reset is low.
  - Reset mid-request abandons it; any stale response after release is not expected and the memory must be reset with this block.
- Output slot:
  - Consumed in a cycle where fetch_valid && !stall_f.
  - Slot free = !fetch_valid || consumed.
  - When the slot is consumed and not refilled, fetch_valid goes to 0 next cycle; instr_f returns to NOP_INSTR; Address_f and PC4_f hold.
- Pending buffer:
  - One internal entry holding {instr, addr}.
  - Filled when a response arrives and the slot is not free.
  - Moves into the slot on the first cycle the slot is free; it has priority over a same-cycle response.
- State REQ:
  - imem_req_valid = !pending_full; imem_req_addr = pc.
  - On valid && ready: inflight_pc <= pc; go to WAIT.
- State WAIT:
  - imem_req_valid = 0.
  - On imem_rsp_valid, data goes to the slot if free and pending is empty, else to pending.
  - Slot load: instr_f=rsp_data, Address_f=inflight_pc, PC4_f=inflight_pc+4, fetch_valid=1.
  - pc <= inflight_pc+4; go to REQ.
  - Minimum latency: request accept at cycle N, response at N+1 gives fetch_valid=1 at N+2.
- State KILL:
  - imem_req_valid = 0.
  - Discard the next imem_rsp_valid, then go to REQ.
- Redirect (highest priority, any state, same cycle as stall allowed):
  - fetch_valid <= 0; pending cleared; pc <= {redirect_pc[31:2], 2'b00}.
  - If in WAIT, or in REQ with a handshake this cycle, go to KILL; otherwise go to REQ.
  - A response arriving in the redirect cycle itself (WAIT) is discarded and counts as the inflight response, so go to REQ, not KILL.
- Stall:
  - stall_f holds instr_f, Address_f, PC4_f and fetch_valid stable.
  - Fetch continues until pending is full, then requests stop.
- Arithmetic: PC+4 is modulo 2^32; 32'hFFFF_FFFC + 4 = 0.
- Throughput: at most one instruction per 2 cycles with single-outstanding fetch.

Test Plan:
- Release reset, RESET_PC=0, memory ready=1, 1-cycle latency returning 0x11,0x22,0x33 -> fetch_valid pulses with (instr,Address,PC4) = (0x11,0,4), (0x22,4,8), (0x33,8,12); no stall, in order.
- During reset -> imem_req_valid=0, fetch_valid=0, instr_f=0x13. Assert reset while in WAIT -> all outputs return to reset values immediately, without waiting for clk.
- Hold stall_f=1 with instr 0x11 in the slot -> outputs stable; next response 0x22 goes to pending; imem_req_valid=0. Release stall -> 0x22 @ addr 4 appears the next cycle.
- Redirect to 0x103 while in WAIT -> old response discarded; next request addr=0x100; fetch_valid=0 until 0x100's instruction returns.
- Redirect in the same cycle as a response and as stall_f=1 with the slot full -> slot and pending cleared, state=REQ, next addr = redirect target.
- Redirect to 0xFFFF_FFFC -> Address_f=0xFFFF_FFFC, PC4_f=0, next request addr=0.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding fetches and
// feeds the IF/ID slot, with a one-entry pending buffer to ride out decode stalls.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall_f,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr_f,
  output logic [31:0] Address_f,
  output logic [31:0] PC4_f,
  output logic        fetch_valid
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_KILL = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] inflight_pc, inflight_pc_nx;
  logic        pend_full, pend_full_nx;
  logic [31:0] pend_instr, pend_instr_nx;
  logic [31:0] pend_addr, pend_addr_nx;
  logic        fetch_valid_nx;
  logic [31:0] instr_nx, addr_nx, pc4_nx;
  logic        consumed, slot_free, handshake, rsp_wait;

  // Requests are held off while reset is low and whenever the pending entry is occupied.
  assign imem_req_valid = reset && (state == S_REQ) && !pend_full;
  assign imem_req_addr  = pc;

  // State, PC, pending buffer and output slot registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      inflight_pc <= 32'h0000_0000;
      pend_full   <= 1'b0;
      pend_instr  <= 32'h0000_0000;
      pend_addr   <= 32'h0000_0000;
      fetch_valid <= 1'b0;
      instr_f     <= NOP_INSTR;
      Address_f   <= 32'h0000_0000;
      PC4_f       <= 32'h0000_0000;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      inflight_pc <= inflight_pc_nx;
      pend_full   <= pend_full_nx;
      pend_instr  <= pend_instr_nx;
      pend_addr   <= pend_addr_nx;
      fetch_valid <= fetch_valid_nx;
      instr_f     <= instr_nx;
      Address_f   <= addr_nx;
      PC4_f       <= pc4_nx;
    end
  end

  // Next-state, slot and pending-buffer update.
  always_comb begin
    state_nx       = state;
    pc_nx          = pc;
    inflight_pc_nx = inflight_pc;
    pend_full_nx   = pend_full;
    pend_instr_nx  = pend_instr;
    pend_addr_nx   = pend_addr;
    fetch_valid_nx = fetch_valid;
    instr_nx       = instr_f;
    addr_nx        = Address_f;
    pc4_nx         = PC4_f;

    consumed  = fetch_valid && !stall_f;
    slot_free = !fetch_valid || consumed;
    handshake = imem_req_valid && imem_req_ready;
    rsp_wait  = (state == S_WAIT) && imem_rsp_valid;

    if (redirect_valid) begin
      fetch_valid_nx = 1'b0;
      instr_nx       = NOP_INSTR;
      pend_full_nx   = 1'b0;
      pc_nx          = redirect_pc & 32'hFFFF_FFFC;
      // A response landing in the redirect cycle is the inflight one, so no kill is needed.
      case (state)
        S_REQ:   state_nx = handshake ? S_KILL : S_REQ;
        S_WAIT:  state_nx = imem_rsp_valid ? S_REQ : S_KILL;
        S_KILL:  state_nx = imem_rsp_valid ? S_REQ : S_KILL;
        default: state_nx = S_REQ;
      endcase
    end else begin
      if (slot_free && pend_full) begin
        fetch_valid_nx = 1'b1;
        instr_nx       = pend_instr;
        addr_nx        = pend_addr;
        pc4_nx         = pend_addr + 32'd4;
        pend_full_nx   = 1'b0;
      end else if (slot_free && rsp_wait) begin
        fetch_valid_nx = 1'b1;
        instr_nx       = imem_rsp_data;
        addr_nx        = inflight_pc;
        pc4_nx         = inflight_pc + 32'd4;
      end else if (consumed) begin
        fetch_valid_nx = 1'b0;
        instr_nx       = NOP_INSTR;
      end else begin
        fetch_valid_nx = fetch_valid;
      end

      if (rsp_wait && (!slot_free || pend_full)) begin
        pend_full_nx  = 1'b1;
        pend_instr_nx = imem_rsp_data;
        pend_addr_nx  = inflight_pc;
      end else begin
        pend_instr_nx = pend_instr;
      end

      case (state)
        S_REQ: begin
          if (handshake) begin
            inflight_pc_nx = pc;
            state_nx       = S_WAIT;
          end else begin
            state_nx = S_REQ;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            pc_nx    = inflight_pc + 32'd4;
            state_nx = S_REQ;
          end else begin
            state_nx = S_WAIT;
          end
        end
        S_KILL: begin
          if (imem_rsp_valid) begin
            state_nx = S_REQ;
          end else begin
            state_nx = S_KILL;
          end
        end
        default: state_nx = S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run
// scored against an in-order program-stream model with a behavioural memory.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall_f;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr_f;
  logic [31:0] Address_f;
  logic [31:0] PC4_f;
  logic        fetch_valid;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural memory: one outstanding request, response after a latency of lat_min..lat_max.
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat_min = 1;
  int          lat_max = 1;
  bit          rand_ready = 1'b0;
  logic        acc;
  logic [31:0] acc_addr;
  logic        rsp_fired;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall_f(stall_f), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_f(instr_f), .Address_f(Address_f), .PC4_f(PC4_f), .fetch_valid(fetch_valid)
  );

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return ((a >> 2) + 32'd1) * 32'h0000_0011;
  endfunction

  // One clock cycle starting and ending at a negedge; caller sets stall/redirect first.
  task automatic cycle();
    if (mem_busy && mem_cnt == 1) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_data(mem_addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    rsp_fired      = imem_rsp_valid;
    imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    acc      = imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    @(posedge clk);
    if (rsp_fired) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (acc) begin
      n_cmp++;
      if (mem_busy !== 1'b0) begin
        n_err++;
        $display("FAIL one_outstanding: request at %h accepted while busy=%b, required busy=0", acc_addr, mem_busy);
      end
      mem_busy = 1'b1;
      mem_cnt  = $urandom_range(lat_min, lat_max);
      mem_addr = acc_addr;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    stall_f        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b0;
    mem_busy       = 1'b0;
    mem_cnt        = 0;
    rand_ready     = 1'b0;
    lat_min        = 1;
    lat_max        = 1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({imem_req_valid, fetch_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_valids: got req=%b fv=%b, required 0 0", imem_req_valid, fetch_valid);
    end
    n_cmp++;
    if ({instr_f, Address_f, PC4_f} !== {32'h13, 32'h0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_slot: got %h %h %h, required 00000013 0 0", instr_f, Address_f, PC4_f);
    end
    do_reset();
    cycle();
    cycle();
    stall_f = 1'b1;
    cycle();
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({imem_req_valid, fetch_valid, instr_f, Address_f, PC4_f} !== {2'b00, 32'h13, 32'h0, 32'h0}) begin
      n_err++;
      $display("FAIL async_reset: got req=%b fv=%b %h %h %h, required 0 0 00000013 0 0",
               imem_req_valid, fetch_valid, instr_f, Address_f, PC4_f);
    end
    @(negedge clk);
    stall_f = 1'b0;
  endtask

  task automatic test_basic();
    do_reset();
    cycle();
    n_cmp++;
    if (fetch_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_latency_early: got fv=%b, required 0", fetch_valid);
    end
    for (int k = 2; k <= 6; k++) begin
      if (k > 2) cycle();
      else cycle();
      n_cmp++;
      if ((k % 2) == 0) begin
        if ({fetch_valid, instr_f, Address_f, PC4_f} !==
            {1'b1, 32'(k / 2) * 32'h11, 32'(k / 2 - 1) * 32'd4, 32'(k / 2) * 32'd4}) begin
          n_err++;
          $display("FAIL basic_stream_%0d: got fv=%b %h %h %h, required 1 %h %h %h", k, fetch_valid,
                   instr_f, Address_f, PC4_f, 32'(k / 2) * 32'h11, 32'(k / 2 - 1) * 32'd4, 32'(k / 2) * 32'd4);
        end
      end else begin
        if ({fetch_valid, instr_f} !== {1'b0, 32'h13}) begin
          n_err++;
          $display("FAIL basic_gap_%0d: got fv=%b instr=%h, required 0 00000013", k, fetch_valid, instr_f);
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    cycle();
    cycle();
    stall_f = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      n_cmp++;
      if ({fetch_valid, instr_f, Address_f, PC4_f} !== {1'b1, 32'h11, 32'h0, 32'h4}) begin
        n_err++;
        $display("FAIL stall_hold_%0d: got fv=%b %h %h %h, required 1 00000011 0 4", k, fetch_valid,
                 instr_f, Address_f, PC4_f);
      end
      if (k >= 1) begin
        n_cmp++;
        if (imem_req_valid !== 1'b0) begin
          n_err++;
          $display("FAIL stall_req_stop_%0d: got req=%b, required 0", k, imem_req_valid);
        end
      end
    end
    stall_f = 1'b0;
    cycle();
    n_cmp++;
    if ({fetch_valid, instr_f, Address_f, PC4_f} !== {1'b1, 32'h22, 32'h4, 32'h8}) begin
      n_err++;
      $display("FAIL stall_release: got fv=%b %h %h %h, required 1 00000022 4 8", fetch_valid,
               instr_f, Address_f, PC4_f);
    end
  endtask

  task automatic test_redirect_wait();
    bit seen_req = 1'b0;
    bit done = 1'b0;
    do_reset();
    lat_min = 3;
    lat_max = 3;
    cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h103;
    cycle();
    redirect_valid = 1'b0;
    n_cmp++;
    if (fetch_valid !== 1'b0) begin
      n_err++;
      $display("FAIL redir_wait_fv: got %b, required 0", fetch_valid);
    end
    for (int k = 0; k < 20 && !done; k++) begin
      cycle();
      if (acc && !seen_req) begin
        seen_req = 1'b1;
        n_cmp++;
        if (acc_addr !== 32'h100) begin
          n_err++;
          $display("FAIL redir_wait_addr: got %h, required 00000100", acc_addr);
        end
      end
      if (fetch_valid) begin
        done = 1'b1;
        n_cmp++;
        if ({instr_f, Address_f, PC4_f} !== {32'h451, 32'h100, 32'h104}) begin
          n_err++;
          $display("FAIL redir_wait_first: got %h %h %h, required 00000451 00000100 00000104",
                   instr_f, Address_f, PC4_f);
        end
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL redir_wait_timeout: got no instruction in 20 cycles, required one");
    end
  endtask

  task automatic test_redirect_same_cycle();
    do_reset();
    cycle();
    cycle();
    stall_f = 1'b1;
    cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    cycle();
    redirect_valid = 1'b0;
    n_cmp++;
    if ({fetch_valid, imem_req_valid, imem_req_addr} !== {2'b01, 32'h200}) begin
      n_err++;
      $display("FAIL redir_same: got fv=%b req=%b addr=%h, required 0 1 00000200", fetch_valid,
               imem_req_valid, imem_req_addr);
    end
    cycle();
    cycle();
    n_cmp++;
    if ({fetch_valid, instr_f, Address_f} !== {1'b1, 32'h891, 32'h200}) begin
      n_err++;
      $display("FAIL redir_same_refill: got fv=%b %h %h, required 1 00000891 00000200", fetch_valid,
               instr_f, Address_f);
    end
    stall_f = 1'b0;
  endtask

  task automatic test_wrap();
    bit done = 1'b0;
    bit seen_req = 1'b0;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      cycle();
      if (acc && !seen_req) begin
        seen_req = 1'b1;
        n_cmp++;
        if (acc_addr !== 32'hFFFF_FFFC) begin
          n_err++;
          $display("FAIL wrap_req: got %h, required fffffffc", acc_addr);
        end
      end
      if (fetch_valid) begin
        done = 1'b1;
        n_cmp++;
        if ({instr_f, Address_f, PC4_f} !== {mem_data(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0}) begin
          n_err++;
          $display("FAIL wrap_slot: got %h %h %h, required %h fffffffc 00000000", instr_f, Address_f,
                   PC4_f, mem_data(32'hFFFF_FFFC));
        end
        n_cmp++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
          n_err++;
          $display("FAIL wrap_next_req: got req=%b addr=%h, required 1 00000000", imem_req_valid, imem_req_addr);
        end
      end
    end
    if (!done) begin
      n_cmp++;
      n_err++;
      $display("FAIL wrap_timeout: got no instruction in 20 cycles, required one");
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_req = 32'h0;
    logic [31:0] tgt;
    logic [96:0] held;
    bit st, rd, hold;
    int consumed = 0;
    do_reset();
    lat_min    = 1;
    lat_max    = 3;
    rand_ready = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      st  = ($urandom_range(0, 99) < 30);
      rd  = ($urandom_range(0, 99) < 4);
      tgt = $urandom;
      stall_f        = st;
      redirect_valid = rd;
      redirect_pc    = tgt;
      if (fetch_valid && !st) begin
        consumed++;
        n_cmp++;
        if ({instr_f, Address_f, PC4_f} !== {mem_data(exp_pc), exp_pc, exp_pc + 32'd4}) begin
          n_err++;
          $display("FAIL rand_stream @%0d: got %h %h %h, required %h %h %h", k, instr_f, Address_f,
                   PC4_f, mem_data(exp_pc), exp_pc, exp_pc + 32'd4);
        end
        exp_pc = exp_pc + 32'd4;
      end
      hold = fetch_valid && st && !rd;
      held = {fetch_valid, instr_f, Address_f, PC4_f};
      cycle();
      if (acc) begin
        n_cmp++;
        if (acc_addr !== exp_req) begin
          n_err++;
          $display("FAIL rand_req_addr @%0d: got %h, required %h", k, acc_addr, exp_req);
        end
        exp_req = exp_req + 32'd4;
      end
      if (rd) begin
        exp_pc  = tgt & 32'hFFFF_FFFC;
        exp_req = tgt & 32'hFFFF_FFFC;
        n_cmp++;
        if (fetch_valid !== 1'b0) begin
          n_err++;
          $display("FAIL rand_redirect_flush @%0d: got fv=%b, required 0", k, fetch_valid);
        end
      end
      if (hold) begin
        n_cmp++;
        if ({fetch_valid, instr_f, Address_f, PC4_f} !== held) begin
          n_err++;
          $display("FAIL rand_stall_hold @%0d: got %h, required %h", k,
                   {fetch_valid, instr_f, Address_f, PC4_f}, held);
        end
      end
    end
    n_cmp++;
    if (consumed < 100) begin
      n_err++;
      $display("FAIL rand_progress: got %0d instructions, required at least 100", consumed);
    end
    stall_f        = 1'b0;
    redirect_valid = 1'b0;
    rand_ready     = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by 1ms, required completion");
    $fatal(1);
  end

  initial begin
    reset          = 1'b0;
    stall_f        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    imem_req_ready = 1'b0;
    mem_busy       = 1'b0;
    mem_cnt        = 0;
    mem_addr       = 32'h0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
